ifft_out_sequencer: RTL and testbench
=====================================

// Module: ifft_out_sequencer
// PURPOSE
//   Output controller for the IFFT word mux. Accepts one full frame (WORDS x WIDTH bits)
//   over a valid/ready handshake and holds it in frame_q. Drives the mux select
//   (data_sel) once per accepted beat and streams the mux result as WIDTH-bit words
//   over a second valid/ready handshake. Optional bit-reversed read order gives the
//   natural-order IFFT output.
// PARAMETERS
//   WORDS    32  words per frame (power of 2)
//   WIDTH    16  bits per word
//   SEL_W     5  select/counter width, = log2(WORDS)
//   BIT_REV   0  1: data_sel = bit-reverse(cnt); 0: data_sel = cnt
// PORTS
//   clk          in   1              clock, rising edge
//   rst_n        in   1              asynchronous reset, active low
//   flush        in   1              synchronous abort of the current frame
//   frame_valid  in   1              frame_data valid
//   frame_ready  out  1              sequencer can accept a frame
//   frame_data   in   WORDS*WIDTH    input frame; word 0 = MSBs (mux select 0)
//   frame_q      out  WORDS*WIDTH    registered frame, wired to the mux data_in
//   data_sel     out  SEL_W          mux select
//   mux_data     in   WIDTH          mux data_out (combinational from frame_q, data_sel)
//   out_data     out  WIDTH          output word, = mux_data
//   out_valid    out  1              out_data valid
//   out_ready    in   1              downstream accepts the word
//   out_last     out  1              current word is the last of the frame
//   busy         out  1              frame in progress (state == SEND)
// BEHAVIOUR
//   Reset (rst_n low, async): state=IDLE, cnt=0, frame_q=0, out_valid=0, out_last=0,
//     busy=0, frame_ready=0 while rst_n is low, frame_ready=1 from the first cycle after release.
//   FSM has 2 states, IDLE and SEND. frame_ready = (state==IDLE).
//   IDLE: when frame_valid & frame_ready, on that edge frame_q<=frame_data, cnt<=0,
//     state<=SEND. No other IDLE transitions.
//   SEND: out_valid=1 and busy=1, both decoded from state.
//     data_sel = BIT_REV ? rev(cnt) : cnt, combinational from cnt.
//     out_data = mux_data. One-cycle combinational path through the external mux.
//   Beat = out_valid & out_ready. On a beat: cnt<=cnt+1.
//     On a beat with cnt==WORDS-1: cnt<=0 and state<=IDLE.
//   out_last = (state==SEND) & (cnt==WORDS-1).
//   Stall rules while out_ready is low:
//     - cnt, data_sel, out_data and out_last hold.
//     - out_valid never drops until the beat completes.
//   Frame changes:
//     - frame_q changes only on frame acceptance.
//     - frame_q is not cleared on return to IDLE.
//   Throughput: WORDS beats per frame, plus 1 IDLE cycle between frames
//     (no back-to-back acceptance).
//   flush:
//     - High in SEND: state<=IDLE and cnt<=0 on the next edge. A same-cycle beat is
//       still counted as transferred downstream.
//     - In IDLE: flush has priority over frame acceptance, so frame_ready=0 while flush=1.
//   Async reset mid-frame: outputs go to reset values immediately and the partial
//     frame is discarded.
//   cnt is SEL_W bits wide. Wrap from WORDS-1 to 0 is explicit, not overflow-reliant.
// TESTING
//   1 Reset: rst_n=0 mid-SEND -> out_valid=0, busy=0, cnt=0 at once; frame_ready=1 one cycle after release.
//   2 BIT_REV=0, frame word k = 16'h1000+k, out_ready=1 -> 32 beats 16'h1000..16'h101F,
//     out_last only on 16'h101F; frame_ready=1 exactly 1 cycle after the last beat.
//   3 BIT_REV=1, same frame -> sequence 16'h1000,16'h1010,16'h1008,16'h1018,...,16'h101F;
//     data_sel = 0,16,8,24,...,31.
//   4 Backpressure: out_ready low for 3 cycles at cnt=5 -> out_valid held, out_data=16'h1005
//     stable, no beat lost or duplicated; 32 total beats.
//   5 flush at cnt=10 with out_ready=1 -> words 0..10 delivered, IDLE next cycle;
//     a new frame then starts at word 0.
//   6 frame_valid held high continuously, out_ready=1 -> frames accepted every 33 cycles,
//     frame_q stable through each SEND.

Source files
------------

// File: rtl/ifft_out_sequencer.sv
// IFFT output sequencer: captures a frame, steps the external word mux select
// and streams the selected words over a valid/ready handshake.
module ifft_out_sequencer #(
  parameter int unsigned WORDS   = 32,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SEL_W   = 5,
  parameter int unsigned BIT_REV = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   frame_valid,
  output logic                   frame_ready,
  input  logic [WORDS*WIDTH-1:0] frame_data,
  output logic [WORDS*WIDTH-1:0] frame_q,
  output logic [SEL_W-1:0]       data_sel,
  input  logic [WIDTH-1:0]       mux_data,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy
);

  localparam int unsigned      FRAME_W  = WORDS * WIDTH;
  localparam logic [SEL_W-1:0] LAST_CNT = SEL_W'(WORDS - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] frame_d;
  logic               run_q, run_d;
  logic [SEL_W-1:0]   cnt_rev;
  logic               accept;
  logic               beat;

  // Status decoded from state; run_q keeps frame_ready low until the first edge after reset.
  assign frame_ready = run_q & (state_q == ST_IDLE) & ~flush;
  assign out_valid   = (state_q == ST_SEND);
  assign busy        = (state_q == ST_SEND);
  assign out_last    = (state_q == ST_SEND) & (cnt_q == LAST_CNT);
  assign out_data    = mux_data;
  assign accept      = frame_valid & frame_ready;
  assign beat        = out_valid & out_ready;

  // Bit-reversed view of the word counter for natural-order IFFT readout.
  always_comb begin
    cnt_rev = '0;
    for (int unsigned b = 0; b < SEL_W; b++) begin
      cnt_rev[SEL_W-1-b] = cnt_q[b];
    end
  end

  // Mux select follows the counter directly or in bit-reversed order.
  assign data_sel = (BIT_REV != 0) ? cnt_rev : cnt_q;

  // Next-state logic: frame capture in IDLE, word stepping and abort in SEND.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    run_d   = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          frame_d = frame_data;
          cnt_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (beat) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + SEL_W'(1'b1);
          end
        end
        if (flush) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and frame registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      run_q   <= run_d;
    end
  end

endmodule

// File: tb/tb_ifft_out_sequencer.sv
// Bench for ifft_out_sequencer: natural and bit-reversed instances share stimulus
// and are checked against a word-level model of the frame stream.
module tb_ifft_out_sequencer;

  localparam int unsigned WORDS = 32;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned SEL_W = 5;
  localparam int unsigned FW    = WORDS * WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, flush, frame_valid, out_ready;
  logic [FW-1:0] frame_data;

  logic             fr0, ov0, ol0, busy0, fr1, ov1, ol1, busy1;
  logic [FW-1:0]    fq0, fq1;
  logic [SEL_W-1:0] sel0, sel1;
  logic [WIDTH-1:0] mux0, mux1, od0, od1;

  ifft_out_sequencer #(.WORDS(WORDS), .WIDTH(WIDTH), .SEL_W(SEL_W), .BIT_REV(0)) u_nat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .frame_valid(frame_valid),
    .frame_ready(fr0), .frame_data(frame_data), .frame_q(fq0), .data_sel(sel0),
    .mux_data(mux0), .out_data(od0), .out_valid(ov0), .out_ready(out_ready),
    .out_last(ol0), .busy(busy0));

  ifft_out_sequencer #(.WORDS(WORDS), .WIDTH(WIDTH), .SEL_W(SEL_W), .BIT_REV(1)) u_rev (
    .clk(clk), .rst_n(rst_n), .flush(flush), .frame_valid(frame_valid),
    .frame_ready(fr1), .frame_data(frame_data), .frame_q(fq1), .data_sel(sel1),
    .mux_data(mux1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready),
    .out_last(ol1), .busy(busy1));

  // External word mux: select 0 picks the MSB word.
  always_comb mux0 = fq0[(WORDS-1-int'(sel0))*WIDTH +: WIDTH];
  always_comb mux1 = fq1[(WORDS-1-int'(sel1))*WIDTH +: WIDTH];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: stored frame words, current word index, frame-in-progress flag.
  logic [WIDTH-1:0] m_frame [WORDS];
  int               m_idx;
  bit               m_busy, m_started;

  logic [WIDTH-1:0] q0[$], q1[$];
  bit               ql[$];
  int               acc_q[$];

  typedef struct {
    logic       fl, fv, ordy;
    logic       e_fr, e_busy, e_last;
    logic [15:0] e_d0, e_d1;
  } vec_t;
  vec_t tbl [9];

  function automatic int rev(input int k);
    int r = 0;
    for (int b = 0; b < int'(SEL_W); b++) if (((k >> b) & 1) != 0) r = r | (1 << (int'(SEL_W) - 1 - b));
    return r;
  endfunction

  function automatic logic [FW-1:0] make_frame(input logic [WIDTH-1:0] base);
    logic [FW-1:0] f;
    for (int k = 0; k < int'(WORDS); k++) f[(int'(WORDS)-1-k)*int'(WIDTH) +: WIDTH] = base + WIDTH'(k);
    return f;
  endfunction

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int k = 0; k < int'(WORDS); k++) f[k*int'(WIDTH) +: WIDTH] = WIDTH'($urandom);
    return f;
  endfunction

  function automatic logic [FW-1:0] m_pack();
    logic [FW-1:0] f;
    for (int k = 0; k < int'(WORDS); k++) f[(int'(WORDS)-1-k)*int'(WIDTH) +: WIDTH] = m_frame[k];
    return f;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic chkf(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < int'(WORDS); k++) m_frame[k] = '0;
    m_idx = 0; m_busy = 0; m_started = 0;
  endtask

  task automatic model_step();
    if (!rst_n) model_reset();
    else if (!m_started) m_started = 1;
    else if (m_busy) begin
      if (flush) begin m_busy = 0; m_idx = 0; end
      else if (out_ready) begin
        if (m_idx == int'(WORDS) - 1) begin m_busy = 0; m_idx = 0; end
        else m_idx++;
      end
    end else if (frame_valid && !flush) begin
      for (int k = 0; k < int'(WORDS); k++) m_frame[k] = frame_data[(int'(WORDS)-1-k)*int'(WIDTH) +: WIDTH];
      m_busy = 1; m_idx = 0;
    end
  endtask

  task automatic model_compare();
    logic e_fr;
    e_fr = rst_n && m_started && !m_busy && !flush;
    chk("frame_ready_nat", 64'(fr0), 64'(e_fr));
    chk("frame_ready_rev", 64'(fr1), 64'(e_fr));
    chk("out_valid_nat", 64'(ov0), 64'(m_busy));
    chk("out_valid_rev", 64'(ov1), 64'(m_busy));
    chk("busy_nat", 64'(busy0), 64'(m_busy));
    chk("busy_rev", 64'(busy1), 64'(m_busy));
    chk("out_last_nat", 64'(ol0), 64'(m_busy && m_idx == int'(WORDS) - 1));
    chk("out_last_rev", 64'(ol1), 64'(m_busy && m_idx == int'(WORDS) - 1));
    chk("data_sel_nat", 64'(sel0), 64'(m_idx));
    chk("data_sel_rev", 64'(sel1), 64'(rev(m_idx)));
    chk("out_data_nat", 64'(od0), 64'(m_frame[m_idx]));
    chk("out_data_rev", 64'(od1), 64'(m_frame[rev(m_idx)]));
    chkf("frame_q_nat", fq0, m_pack());
    chkf("frame_q_rev", fq1, m_pack());
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_compare();
    if (ov0 && out_ready) begin q0.push_back(od0); q1.push_back(od1); ql.push_back(ol0); end
    if (frame_valid && fr0) acc_q.push_back(cyc);
  endtask

  task automatic at_pos();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick();
    at_neg();
    at_pos();
  endtask

  task automatic clear_q();
    q0.delete(); q1.delete(); ql.delete(); acc_q.delete();
  endtask

  task automatic wait_beats(input int n, input string nm);
    int t = 0;
    while (q0.size() < n && t < 200) begin tick(); t++; end
    chk(nm, 64'(q0.size()), 64'(n));
  endtask

  task automatic wait_sel(input int s);
    int t = 0;
    while (int'(sel0) != s && t < 100) begin tick(); t++; end
    chk("reach_sel", 64'(sel0), 64'(s));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; frame_valid = 1'b0; out_ready = 1'b0;
    frame_data = make_frame(16'h1000);
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Handshake vectors right after reset (frame_q still zero until the accept in row 2).
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1000, 16'h1000};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1000, 16'h1000};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1001, 16'h1010};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1001, 16'h1010};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1000, 16'h1000};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1000, 16'h1000};
    for (int i = 0; i < 9; i++) begin
      flush = tbl[i].fl; frame_valid = tbl[i].fv; out_ready = tbl[i].ordy;
      at_neg();
      chk("tbl_frame_ready", 64'(fr0), 64'(tbl[i].e_fr));
      chk("tbl_busy", 64'(busy1), 64'(tbl[i].e_busy));
      chk("tbl_out_valid", 64'(ov0), 64'(tbl[i].e_busy));
      chk("tbl_out_last", 64'(ol0), 64'(tbl[i].e_last));
      chk("tbl_data_nat", 64'(od0), 64'(tbl[i].e_d0));
      chk("tbl_data_rev", 64'(od1), 64'(tbl[i].e_d1));
      at_pos();
    end
    flush = 1'b0; frame_valid = 1'b0; out_ready = 1'b0;

    // Full frame in natural and bit-reversed order.
    clear_q();
    frame_valid = 1'b1; out_ready = 1'b1;
    tick();
    frame_valid = 1'b0;
    wait_beats(32, "full_frame_beats");
    for (int i = 0; i < q0.size(); i++) begin
      chk("seq_nat", 64'(q0[i]), 64'(16'h1000 + 16'(i)));
      chk("seq_rev", 64'(q1[i]), 64'(16'h1000 + 16'(rev(i))));
      chk("seq_last", 64'(ql[i]), 64'(i == 31));
    end
    if (q1.size() == 32) begin
      chk("rev_w1", 64'(q1[1]), 64'(16'h1010));
      chk("rev_w2", 64'(q1[2]), 64'(16'h1008));
      chk("rev_w3", 64'(q1[3]), 64'(16'h1018));
      chk("rev_w31", 64'(q1[31]), 64'(16'h101F));
    end
    at_neg();
    chk("ready_after_last", 64'(fr0), 64'(1));
    at_pos();

    // Backpressure at word 5.
    clear_q();
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    wait_sel(5);
    out_ready = 1'b0;
    repeat (3) begin
      at_neg();
      chk("stall_data", 64'(od0), 64'(16'h1005));
      chk("stall_valid", 64'(ov0), 64'(1));
      chk("stall_sel", 64'(sel0), 64'(5));
      at_pos();
    end
    out_ready = 1'b1;
    wait_beats(32, "stall_frame_beats");
    for (int i = 0; i < q0.size(); i++) chk("stall_seq", 64'(q0[i]), 64'(16'h1000 + 16'(i)));

    // Flush at word 10, then a fresh frame starts at word 0.
    tick();
    clear_q();
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    wait_sel(10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_beats", 64'(q0.size()), 64'(11));
    if (q0.size() == 11) chk("flush_last_word", 64'(q0[10]), 64'(16'h100A));
    at_neg();
    chk("flush_idle", 64'(busy0), 64'(0));
    at_pos();
    clear_q();
    frame_data = make_frame(16'h2000);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    wait_beats(1, "new_frame_first");
    if (q0.size() >= 1) begin
      chk("new_frame_w0_nat", 64'(q0[0]), 64'(16'h2000));
      chk("new_frame_w0_rev", 64'(q1[0]), 64'(16'h2000));
    end
    wait_beats(32, "new_frame_beats");
    tick();

    // Async reset mid-frame.
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(ov0), 64'(0));
    chk("rst_busy", 64'(busy1), 64'(0));
    chk("rst_sel", 64'(sel0), 64'(0));
    chk("rst_last", 64'(ol0), 64'(0));
    chk("rst_ready", 64'(fr0), 64'(0));
    chkf("rst_frame_q", fq0, '0);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    at_neg();
    chk("ready_after_release", 64'(fr0), 64'(1));
    at_pos();

    // Continuous frame_valid: one acceptance every 33 cycles, changing input data.
    clear_q();
    frame_valid = 1'b1; out_ready = 1'b1;
    repeat (110) begin
      frame_data = rand_frame();
      tick();
    end
    frame_valid = 1'b0;
    chk("accept_count", 64'(acc_q.size()), 64'(4));
    for (int i = 1; i < acc_q.size(); i++) chk("accept_period", 64'(acc_q[i] - acc_q[i-1]), 64'(33));
    begin
      int t = 0;
      while (busy0 && t < 100) begin tick(); t++; end
      chk("drain_idle", 64'(busy0), 64'(0));
    end

    // Randomised traffic against the model.
    repeat (3000) begin
      out_ready   = ($urandom_range(0, 9) < 7);
      frame_valid = 1'($urandom_range(0, 1));
      flush       = ($urandom_range(0, 99) < 3);
      frame_data  = rand_frame();
      tick();
      clear_q();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
